// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-read-port register file.
// Holds the clear/run state type and the supported read-port limit.
package regfile_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_e;

  localparam int NRD_MAX = 4;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the register file.
// The register file is the slave; the pipeline drives it through the master modport.
interface reg_file_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
) ();

  localparam int AW = $clog2(DEPTH);

  logic                   Ready;
  logic [NRD*AW-1:0]      rd_addr;
  logic [NRD*WIDTH-1:0]   rd_data;
  logic [NRD-1:0]         rd_busy;
  logic                   RegWrite;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       WD;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_conflict;

  modport master (
    input  Ready, rd_data, rd_busy, rsv_conflict,
    output rd_addr, RegWrite, wa, WD, rsv_en, rsv_addr
  );

  modport slave (
    output Ready, rd_data, rd_busy, rsv_conflict,
    input  rd_addr, RegWrite, wa, WD, rsv_en, rsv_addr
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits for hazard detection, with per-port lookups and a
// registered flag for reservations issued to registers that are already busy.
module rf_scoreboard #(
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_en,
  input  logic [AW-1:0]     wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic              rsv_conflict
);

  logic [DEPTH-1:0] busy;
  logic             rel_ok;
  logic             rsv_ok;

  assign rel_ok = run && wr_en && (wa != '0);
  assign rsv_ok = run && rsv_en && (rsv_addr != '0);

  // Reservation is applied after release so a same-edge write+reserve stays busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      if (rel_ok) begin
        busy[wa] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
      rsv_conflict <= rsv_ok && busy[rsv_addr] && !(wr_en && (wa == rsv_addr));
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = run && busy[rd_addr[i*AW +: AW]] && !(wr_en && (wa == rd_addr[i*AW +: AW]));
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised integer register file: NRD combinational read ports with write
// bypass, busy scoreboard, and a sequential zero-fill of every register after reset.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
) (
  input  logic           CLK,
  input  logic           RST,
  reg_file_mp_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  if (NRD < 1 || NRD > NRD_MAX) begin : g_bad_nrd
    $error("reg_file_mp: NRD must be between 1 and NRD_MAX");
  end

  logic [WIDTH-1:0]     mem [DEPTH];
  rf_state_e            state;
  logic [AW-1:0]        clr_cnt;
  logic                 ready_q;
  logic                 run;
  logic                 wr_ok;
  logic [NRD*WIDTH-1:0] rd_data;

  assign run   = (state == RUN);
  assign wr_ok = run && bus.RegWrite && (bus.wa != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage is not reset; the clear walk zeroes one entry per cycle instead.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (!run) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        mem[bus.wa] <= bus.WD;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && (bus.rd_addr[i*AW +: AW] != '0)) begin
        if (wr_ok && (bus.wa == bus.rd_addr[i*AW +: AW])) begin
          rd_data[i*WIDTH +: WIDTH] = bus.WD;
        end else begin
          rd_data[i*WIDTH +: WIDTH] = mem[bus.rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.Ready   = ready_q;

  rf_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk          (CLK),
    .rst          (RST),
    .run          (run),
    .wr_en        (bus.RegWrite),
    .wa           (bus.wa),
    .rsv_en       (bus.rsv_en),
    .rsv_addr     (bus.rsv_addr),
    .rd_addr      (bus.rd_addr),
    .rd_busy      (bus.rd_busy),
    .rsv_conflict (bus.rsv_conflict)
  );

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RISC-V core, successor to the fixed 32x32 two-read-port file. It adds a configurable read-port count, same-cycle write-to-read bypass, a per-register busy scoreboard for pipelined hazard detection, and a sequential post-reset clear of all registers. It sits between decode (read addresses, reservations) and writeback (write port).

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; power of two, at least 2
- AW, $clog2(DEPTH), register address width (derived)
- NRD, 2, number of read ports, 1..4
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- Ready  out  1  high once the clear sequence has completed
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NRD  port i's register has an outstanding reservation
- RegWrite  in  1  write enable
- wa  in  AW  write address
- WD  in  WIDTH  write data
- rsv_en  in  1  reserve (mark busy) register rsv_addr
- rsv_addr  in  AW  register to reserve
- rsv_conflict  out  1  registered flag: reservation issued to an already-busy register

## Operation
- Two states: CLEAR, RUN. RST high -> CLEAR, clear counter = 0, all busy bits = 0, Ready = 0, rsv_conflict = 0.
- CLEAR: each cycle with RST low writes 0 to mem[counter] and increments the counter; on the cycle counter == DEPTH-1, go to RUN and set Ready = 1. RegWrite and rsv_en are ignored; rd_data = 0 and rd_busy = 0 on every port.
- RUN: stays in RUN until RST.
- Register 0 is hardwired zero: it always reads 0; writes and reservations to address 0 are dropped; busy[0] is always 0.
- Read (combinational): rd_data[i] = WD if RegWrite && wa == rd_addr[i] && wa != 0; otherwise mem[rd_addr[i]].
- Write: on the edge, if RegWrite && wa != 0, then mem[wa] <= WD and busy[wa] <= 0.
- Reserve: on the edge, if rsv_en && rsv_addr != 0, then busy[rsv_addr] <= 1.
- Same edge, same address for write and reserve: the reservation wins, and busy stays 1 (new producer issued).
- rd_busy[i] = busy[rd_addr[i]] && !(RegWrite && wa == rd_addr[i]). A write in the current cycle resolves the hazard combinationally.
- rsv_conflict <= rsv_en && rsv_addr != 0 && busy[rsv_addr] && !(RegWrite && wa == rsv_addr). It is a one-cycle pulse. The reservation still takes effect.
- All read ports are independent. Any ports may address the same register.

## Timing
- Read latency 0 (combinational from rd_addr, RegWrite, wa, WD).
- Write-to-storage latency 1 edge; bypass makes the data visible in the same cycle.
- Reserve-to-rd_busy latency 1 edge.
- Ready rises on the DEPTH-th rising edge after RST is sampled low. Example: DEPTH=32, RST low at edge 0 -> Ready high after edge 32.
- RST asserted mid-RUN or mid-CLEAR restarts the clear from counter 0 on the next edge, drops Ready, and clears all busy bits.
- Outputs after reset: Ready=0, rsv_conflict=0, rd_data=0, rd_busy=0.

## Structure
- Shared package regfile_pkg holds the state enum {CLEAR, RUN} and the NRD upper limit constant.
- Sub-module rf_scoreboard: DEPTH busy bits with reserve/release/reset, NRD busy lookups with write-resolve, and the rsv_conflict register.
- The top level holds the storage array, the clear FSM/counter, and the bypass muxes.

## Test plan
- Reset clear: preload mem[5] = 0xDEAD, pulse RST, read port 0 at address 5 -> Ready low for 32 cycles, then Ready=1 and rd_data = 0.
- Write/bypass: RegWrite=1, wa=7, WD=0x1234, rd_addr[0]=7 in the same cycle -> rd_data[0] = 0x1234 that cycle; WD changed to 0 next cycle with RegWrite=0 -> still reads 0x1234.
- x0: RegWrite, wa=0, WD=0xFFFFFFFF plus rsv_en on address 0 -> reads 0, rd_busy = 0, rsv_conflict = 0.
- Scoreboard: reserve 9 -> rd_busy for address 9 = 1 next cycle; write 9 -> rd_busy = 0 in the write cycle; reserve and write 9 on the same edge -> busy stays 1.
- Conflict: reserve 3 twice on consecutive cycles -> rsv_conflict = 1 for exactly one cycle; reserve 3 while writing 3 -> rsv_conflict = 0.
- Mid-run reset: NRD=4, reserve 4 registers, assert RST -> all rd_busy = 0, Ready = 0, contents zeroed after DEPTH cycles.
